cordic_iter_sequencer: RTL

Multi-cycle controller around the combinational CORDIC iteration stage: accepts one complex sample through a valid/ready handshake, folds it into the right half-plane, then drives the iteration stage for `N_ITER` consecutive cycles and registers its result after each one. The final vectoring result (magnitude-scaled `re`, residual `im`, angle `phi`) is presented through a second valid/ready handshake. The sequencer sits directly upstream of the iteration stage, feeding its `re/im/phi/iter` inputs, and directly downstream of it, consuming its `re/im/phi` outputs.

---
 rtl/cordic_iter_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/cordic_iter_sequencer.sv
// Sequencer for a combinational CORDIC vectoring stage: folds one sample into the right half-plane, then runs N_ITER iterations.
// Result appears N_ITER cycles after accept; in_ready only in IDLE, result held in DONE until out_ready.
module cordic_iter_sequencer #(
  parameter int N_ITER = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_re,
  input  logic [11:0] in_im,
  output logic [11:0] it_re,
  output logic [11:0] it_im,
  output logic [10:0] it_phi,
  output logic [3:0]  it_iter,
  input  logic [11:0] it_re_res,
  input  logic [11:0] it_im_res,
  input  logic [10:0] it_phi_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_re,
  output logic [11:0] out_im,
  output logic [10:0] out_phi
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST = 4'(N_ITER - 1);

  logic [1:0]  state;
  logic [11:0] wre;
  logic [11:0] wim;
  logic [10:0] wphi;
  logic [3:0]  cnt;

  // -2048 has no positive 12-bit counterpart, so clamp it to +2047
  function automatic logic [11:0] neg_sat(input logic [11:0] x);
    if (x == 12'h800) return 12'h7FF;
    return 12'(-x);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wre   <= '0;
      wim   <= '0;
      wphi  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_re[11]) begin
              wre  <= neg_sat(in_re);
              wim  <= neg_sat(in_im);
              wphi <= 11'd1024;
            end else begin
              wre  <= in_re;
              wim  <= in_im;
              wphi <= 11'd0;
            end
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          wre  <= it_re_res;
          wim  <= it_im_res;
          wphi <= it_phi_res;
          if (cnt == LAST) state <= DONE;
          else             cnt   <= cnt + 4'd1;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign it_re   = wre;
  assign it_im   = wim;
  assign it_phi  = wphi;
  assign it_iter = cnt;
  assign out_re  = wre;
  assign out_im  = wim;
  assign out_phi = wphi;

endmodule
